// File: rtl/sync_fifo_bram.sv
// sync_fifo_bram: single-clock FIFO over an inferred block RAM with registered read port,
// occupancy count, almost-full/almost-empty thresholds and overflow/underflow pulses.
`default_nettype none

module sync_fifo_bram #(
  parameter int DATA_WIDTH = 15,
  parameter int ADDR_WIDTH = 11,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 4,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH       = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_depth    = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] c_af_level = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] c_ae_level = (ADDR_WIDTH + 1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q;
  logic                  overflow_q;
  logic                  underflow_q;

  logic w_wr_acc;
  logic w_rd_acc;

  // Status flags come only from the registered count, so no comb path from wr_en/rd_en.
  assign full         = (count_q == c_depth);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= c_af_level);
  assign almost_empty = (count_q <= c_ae_level);

  assign w_wr_acc = wr_en && !full;
  assign w_rd_acc = rd_en && !empty;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (w_wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (w_rd_acc) begin
      rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end
    case ({w_wr_acc, w_rd_acc})
      2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is deliberately unreset so it maps onto block RAM; a write can never
  // collide with an accepted read of the same slot because of the full/empty gating.
  always_ff @(posedge clk) begin
    if (w_wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= w_rd_acc;
      overflow_q  <= wr_en && full;
      underflow_q <= rd_en && empty;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_bram.sv
// Directed self-checking bench for sync_fifo_bram at DEPTH=8, AF_LEVEL=6, AE_LEVEL=1.
`default_nettype none

module tb_sync_fifo_bram;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  int n_checks = 0;
  int n_errors = 0;

  sync_fifo_bram #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AF_LEVEL  (6),
    .AE_LEVEL  (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs and checks happen 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, " rd_data"}, 32'(rd_data), 32'h0);
    check_eq({tag, " rd_valid"}, 32'(rd_valid), 32'd0);
    check_eq({tag, " count"}, 32'(count), 32'd0);
    check_eq({tag, " empty"}, 32'(empty), 32'd1);
    check_eq({tag, " full"}, 32'(full), 32'd0);
    check_eq({tag, " almost_empty"}, 32'(almost_empty), 32'd1);
    check_eq({tag, " almost_full"}, 32'(almost_full), 32'd0);
    check_eq({tag, " overflow"}, 32'(overflow), 32'd0);
    check_eq({tag, " underflow"}, 32'(underflow), 32'd0);
  endtask

  initial begin
    #2;
    check_reset_values("reset");
    tick();
    tick();
    rst_n = 1'b1;

    // Fill 0x01..0x08 and watch thresholds.
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wr_data = DW'(i);
      tick();
      check_eq("fill count", 32'(count), 32'(i));
      check_eq("fill almost_empty", 32'(almost_empty), (i <= 1) ? 32'd1 : 32'd0);
      check_eq("fill almost_full", 32'(almost_full), (i >= 6) ? 32'd1 : 32'd0);
      check_eq("fill full", 32'(full), (i == 8) ? 32'd1 : 32'd0);
      check_eq("fill overflow", 32'(overflow), 32'd0);
    end

    // Write while full is rejected.
    wr_data = 8'h55;
    tick();
    check_eq("ovf pulse", 32'(overflow), 32'd1);
    check_eq("ovf count", 32'(count), 32'd8);
    wr_en = 1'b0;
    tick();
    check_eq("ovf one cycle", 32'(overflow), 32'd0);

    // Drain: 0x01..0x08, 0x55 never appears.
    for (int i = 1; i <= 8; i++) begin
      rd_en = 1'b1;
      tick();
      check_eq("drain rd_valid", 32'(rd_valid), 32'd1);
      check_eq("drain rd_data", 32'(rd_data), 32'(i));
    end
    rd_en = 1'b0;
    tick();
    check_eq("drain valid drop", 32'(rd_valid), 32'd0);
    check_eq("drain empty", 32'(empty), 32'd1);
    check_eq("drain hold data", 32'(rd_data), 32'h08);

    // Read while empty.
    rd_en = 1'b1;
    tick();
    check_eq("unf pulse", 32'(underflow), 32'd1);
    check_eq("unf rd_valid", 32'(rd_valid), 32'd0);
    check_eq("unf rd_data", 32'(rd_data), 32'h08);
    check_eq("unf count", 32'(count), 32'd0);
    rd_en = 1'b0;
    tick();
    check_eq("unf one cycle", 32'(underflow), 32'd0);

    // Steady occupancy 4 with simultaneous traffic across pointer wrap.
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = DW'(8'h10 + i);
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = DW'(8'h14 + k);
      tick();
      check_eq("stream count", 32'(count), 32'd4);
      check_eq("stream rd_valid", 32'(rd_valid), 32'd1);
      check_eq("stream rd_data", 32'(rd_data), 32'(8'h10 + k));
    end
    wr_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("stream tail", 32'(rd_data), 32'(8'h24 + k));
    end
    rd_en = 1'b0;
    tick();
    check_eq("stream empty", 32'(empty), 32'd1);

    // Full with simultaneous wr/rd: read wins.
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = DW'(8'hA0 + i);
      tick();
    end
    check_eq("full2", 32'(full), 32'd1);
    rd_en = 1'b1; wr_data = 8'hAA;
    tick();
    check_eq("fullrw rd_data", 32'(rd_data), 32'hA0);
    check_eq("fullrw rd_valid", 32'(rd_valid), 32'd1);
    check_eq("fullrw count", 32'(count), 32'd7);
    check_eq("fullrw overflow", 32'(overflow), 32'd1);
    check_eq("fullrw full", 32'(full), 32'd0);
    wr_en = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick();
      check_eq("fullrw drain", 32'(rd_data), 32'(8'hA0 + i));
    end
    check_eq("fullrw drained", 32'(empty), 32'd1);

    // Empty with simultaneous wr/rd: write wins.
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h33;
    tick();
    check_eq("emptyrw underflow", 32'(underflow), 32'd1);
    check_eq("emptyrw count", 32'(count), 32'd1);
    check_eq("emptyrw rd_valid", 32'(rd_valid), 32'd0);
    check_eq("emptyrw rd_data", 32'(rd_data), 32'hA7);
    wr_en = 1'b0;
    tick();
    check_eq("emptyrw readback", 32'(rd_data), 32'h33);
    check_eq("emptyrw readvalid", 32'(rd_valid), 32'd1);
    check_eq("emptyrw count0", 32'(count), 32'd0);
    rd_en = 1'b0;

    // Mid-stream asynchronous reset with count 5 and rd_valid high.
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = DW'(8'h40 + i);
      tick();
    end
    rd_en = 1'b1; wr_data = 8'h45;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check_eq("pre-reset count", 32'(count), 32'd5);
    check_eq("pre-reset rd_valid", 32'(rd_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async reset");
    tick();
    rst_n = 1'b1;
    wr_en = 1'b1; wr_data = 8'h7F;
    tick();
    check_eq("post-reset count", 32'(count), 32'd1);
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    check_eq("post-reset rd_data", 32'(rd_data), 32'h7F);
    check_eq("post-reset rd_valid", 32'(rd_valid), 32'd1);
    rd_en = 1'b0;
    tick();
    check_eq("post-reset valid drop", 32'(rd_valid), 32'd0);
    check_eq("post-reset empty", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
